// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with bubble (FlushE) and hold (StallE) control,
// plus saturating bubble/stall performance counters.
module id_ex_pipe_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             FlushE,
    input  logic             StallE,
    input  logic             CntClr,
    input  logic             ValidD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic [2:0]       ALUControlD,
    input  logic             ALUSrcD,
    output logic             ValidE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             RegWriteE,
    output logic [1:0]       ResultSrcE,
    output logic             MemWriteE,
    output logic             JumpE,
    output logic             BranchE,
    output logic [2:0]       ALUControlE,
    output logic             ALUSrcE,
    output logic [CNT_W-1:0] BubbleCnt,
    output logic [CNT_W-1:0] StallCnt
);

    localparam logic [CNT_W-1:0] cntMax = '1;

    // Stage register: a flush loads an all-zero bubble, a stall holds, otherwise capture D
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidE      <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            ImmExtE     <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            RegWriteE   <= 1'b0;
            ResultSrcE  <= '0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= '0;
            ALUSrcE     <= 1'b0;
        end else if (FlushE) begin
            ValidE      <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            ImmExtE     <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            RegWriteE   <= 1'b0;
            ResultSrcE  <= '0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= '0;
            ALUSrcE     <= 1'b0;
        end else if (!StallE) begin
            ValidE      <= ValidD;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
            ImmExtE     <= ImmExtD;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= RdD;
            RegWriteE   <= RegWriteD;
            ResultSrcE  <= ResultSrcD;
            MemWriteE   <= MemWriteD;
            JumpE       <= JumpD;
            BranchE     <= BranchD;
            ALUControlE <= ALUControlD;
            ALUSrcE     <= ALUSrcD;
        end
    end

    // Perf counters: clear beats increment; flush counts as a bubble even when stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BubbleCnt <= '0;
            StallCnt  <= '0;
        end else if (CntClr) begin
            BubbleCnt <= '0;
            StallCnt  <= '0;
        end else if (FlushE) begin
            if (BubbleCnt != cntMax) BubbleCnt <= BubbleCnt + CNT_W'(1);
        end else if (StallE) begin
            if (StallCnt != cntMax) StallCnt <= StallCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: a behavioural model pushes expected E-stage contents
// each edge; a monitor pops and compares both a 16-bit and a 4-bit-counter instance.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic [31:0] rd1, rd2, pc, pcp4, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        regWrite;
        logic [1:0]  resultSrc;
        logic        memWrite, jump, branch;
        logic [2:0]  aluCtl;
        logic        aluSrc, valid;
    } stage_t;

    typedef struct {
        stage_t st;
        int     bub, stl, bubS, stlS;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic FlushE = 0, StallE = 0, CntClr = 0, ValidD = 0;
    logic [31:0] RD1D = 0, RD2D = 0, PCD = 0, PCPlus4D = 0, ImmExtD = 0;
    logic [4:0]  Rs1D = 0, Rs2D = 0, RdD = 0;
    logic        RegWriteD = 0, MemWriteD = 0, JumpD = 0, BranchD = 0, ALUSrcD = 0;
    logic [1:0]  ResultSrcD = 0;
    logic [2:0]  ALUControlD = 0;

    logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [15:0] BubbleCnt, StallCnt;

    logic        sValidE, sRegWriteE, sMemWriteE, sJumpE, sBranchE, sALUSrcE;
    logic [31:0] sRD1E, sRD2E, sPCE, sPCPlus4E, sImmExtE;
    logic [4:0]  sRs1E, sRs2E, sRdE;
    logic [1:0]  sResultSrcE;
    logic [2:0]  sALUControlE;
    logic [3:0]  sBubbleCnt, sStallCnt;

    id_ex_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .FlushE(FlushE), .StallE(StallE), .CntClr(CntClr),
        .ValidD(ValidD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
        .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
        .ValidE(ValidE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
        .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .BubbleCnt(BubbleCnt), .StallCnt(StallCnt)
    );

    id_ex_pipe_reg #(.XLEN(32), .CNT_W(4)) dutSat (
        .clk(clk), .rst_n(rst_n), .FlushE(FlushE), .StallE(StallE), .CntClr(CntClr),
        .ValidD(ValidD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
        .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
        .ValidE(sValidE), .RD1E(sRD1E), .RD2E(sRD2E), .PCE(sPCE), .PCPlus4E(sPCPlus4E),
        .ImmExtE(sImmExtE), .Rs1E(sRs1E), .Rs2E(sRs2E), .RdE(sRdE), .RegWriteE(sRegWriteE),
        .ResultSrcE(sResultSrcE), .MemWriteE(sMemWriteE), .JumpE(sJumpE), .BranchE(sBranchE),
        .ALUControlE(sALUControlE), .ALUSrcE(sALUSrcE),
        .BubbleCnt(sBubbleCnt), .StallCnt(sStallCnt)
    );

    always #5 clk = ~clk;

    stage_t dIn, actE, satE;
    always_comb begin
        dIn = '{RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD,
                MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD, ValidD};
        actE = '{RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE,
                 MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE, ValidE};
        satE = '{sRD1E, sRD2E, sPCE, sPCPlus4E, sImmExtE, sRs1E, sRs2E, sRdE, sRegWriteE,
                 sResultSrcE, sMemWriteE, sJumpE, sBranchE, sALUControlE, sALUSrcE, sValidE};
    end

    int nChecks = 0;
    int nFail = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: E contents plus unbounded counters clamped to each instance's maximum
    stage_t mSt = '0;
    int mBub = 0, mStl = 0, mBubS = 0, mStlS = 0;
    exp_t q[$];

    function automatic int satInc(input int v, input int maxV);
        return (v + 1 > maxV) ? maxV : v + 1;
    endfunction

    always @(negedge rst_n) begin
        mSt = '0; mBub = 0; mStl = 0; mBubS = 0; mStlS = 0;
    end

    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mSt = '0; mBub = 0; mStl = 0; mBubS = 0; mStlS = 0;
        end else begin
            if (FlushE) mSt = '0;
            else if (!StallE) mSt = dIn;
            if (CntClr) begin
                mBub = 0; mStl = 0; mBubS = 0; mStlS = 0;
            end else if (FlushE) begin
                mBub = satInc(mBub, 65535); mBubS = satInc(mBubS, 15);
            end else if (StallE) begin
                mStl = satInc(mStl, 65535); mStlS = satInc(mStlS, 15);
            end
        end
        e.st = mSt; e.bub = mBub; e.stl = mStl; e.bubS = mBubS; e.stlS = mStlS;
        q.push_back(e);
    end

    // Monitor: every edge presents a new E-stage value
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stageE", 256'(actE), 256'(e.st));
            chk("BubbleCnt", 256'(BubbleCnt), 256'(e.bub));
            chk("StallCnt", 256'(StallCnt), 256'(e.stl));
            chk("satStageE", 256'(satE), 256'(e.st));
            chk("satBubbleCnt", 256'(sBubbleCnt), 256'(e.bubS));
            chk("satStallCnt", 256'(sStallCnt), 256'(e.stlS));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic randD();
        RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = $urandom;
        ImmExtD = $urandom;
        Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
        RegWriteD = 1'($urandom); ResultSrcD = 2'($urandom); MemWriteD = 1'($urandom);
        JumpD = 1'($urandom); BranchD = 1'($urandom); ALUControlD = 3'($urandom);
        ALUSrcD = 1'($urandom); ValidD = 1'($urandom);
    endtask

    task automatic zeroD();
        RD1D = 0; RD2D = 0; PCD = 0; PCPlus4D = 0; ImmExtD = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
        RegWriteD = 0; ResultSrcD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0;
        ALUControlD = 0; ALUSrcD = 0; ValidD = 0;
    endtask

    initial begin
        tick(); tick();
        rst_n = 1'b1;

        // Mid-cycle async reset with non-zero D and E contents
        RD1D = 32'h1111_1111; RD2D = 32'h2222_2222; PCD = 32'h40; PCPlus4D = 32'h44;
        ImmExtD = 32'h7; Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3; RegWriteD = 1; ResultSrcD = 2'b11;
        MemWriteD = 1; JumpD = 1; BranchD = 1; ALUControlD = 3'd5; ALUSrcD = 1; ValidD = 1;
        tick(); StallE = 1; tick(); StallE = 0; tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rstStageE", 256'(actE), 256'(0));
        chk("rstBubbleCnt", 256'(BubbleCnt), 256'(0));
        chk("rstStallCnt", 256'(StallCnt), 256'(0));
        #1 rst_n = 1'b1;

        // Pass-through
        zeroD(); RdD = 5'd5; RD1D = 32'hDEAD_BEEF; ResultSrcD = 2'b01; ValidD = 1;
        tick();
        chk("passRdE", 256'(RdE), 256'(5));
        chk("passRD1E", 256'(RD1E), 256'(32'hDEAD_BEEF));
        chk("passResultSrcE", 256'(ResultSrcE), 256'(2'b01));
        chk("passValidE", 256'(ValidE), 256'(1));

        // Flush after a load
        RdD = 5'd7; RegWriteD = 1; tick();
        FlushE = 1; tick(); FlushE = 0;
        chk("flushRdE", 256'(RdE), 256'(0));
        chk("flushRegWriteE", 256'(RegWriteE), 256'(0));
        chk("flushResultSrcE", 256'(ResultSrcE), 256'(0));
        chk("flushValidE", 256'(ValidE), 256'(0));
        chk("flushBubbleCnt", 256'(BubbleCnt), 256'(1));

        // Stall holds for three edges
        PCD = 32'h100; tick();
        StallE = 1; PCD = 32'h104; tick(); tick(); tick();
        chk("stallPCE", 256'(PCE), 256'(32'h100));
        chk("stallStallCnt", 256'(StallCnt), 256'(3));
        StallE = 0; tick();
        chk("releasePCE", 256'(PCE), 256'(32'h104));

        // Flush and stall together, then clear alongside a flush
        FlushE = 1; StallE = 1; tick();
        chk("fsValidE", 256'(ValidE), 256'(0));
        chk("fsPCE", 256'(PCE), 256'(0));
        chk("fsBubbleCnt", 256'(BubbleCnt), 256'(2));
        chk("fsStallCnt", 256'(StallCnt), 256'(3));
        StallE = 0; CntClr = 1; tick(); CntClr = 0;
        chk("clrBubbleCnt", 256'(BubbleCnt), 256'(0));
        chk("clrStallCnt", 256'(StallCnt), 256'(0));

        // Saturation of the 4-bit instance
        for (int i = 0; i < 20; i++) tick();
        chk("satBubble15", 256'(sBubbleCnt), 256'(15));
        chk("bubble20", 256'(BubbleCnt), 256'(20));
        tick();
        chk("satBubbleHold", 256'(sBubbleCnt), 256'(15));
        FlushE = 0;

        // Randomized traffic with one mid-cycle reset
        for (int i = 0; i < 2000; i++) begin
            randD();
            FlushE = ($urandom_range(0, 99) < 20);
            StallE = ($urandom_range(0, 99) < 25);
            CntClr = ($urandom_range(0, 99) < 2);
            if (i == 1000) begin
                #3 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick();
        end
        FlushE = 0; StallE = 0; CntClr = 0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
